memory_unit: RTL and testbench

Word-addressed 64 x 16 data/program memory that answers the CPU's memory port (addr, data, we in; mem out), i.e. the responder side of the CPU's MAR/MDR bus. After reset it zero-sweeps its array, then accepts a program image through a valid/ready loader port starting at the CPU's reset PC (address 8), and only then releases the CPU via `run`. In RUN it gives combinational reads and synchronous writes, so the CPU's MAR-load / MDR-load two-cycle access pattern works unchanged.

---
 rtl/memory_unit.sv | 117 +++++++++++
 tb/tb_memory_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/memory_unit.sv
// Word-addressed program/data memory for the CPU's MAR/MDR port.
// After reset it zero-sweeps the array, accepts a program image from the loader, then releases the CPU.
module memory_unit #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 6,
    parameter int LOAD_BASE  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  we,
    output logic [DATA_WIDTH-1:0] mem,
    input  logic                  ld_valid,
    input  logic [DATA_WIDTH-1:0] ld_data,
    input  logic                  ld_last,
    output logic                  ld_ready,
    output logic                  run,
    output logic                  ld_err
);

    localparam int                    DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] TOP_ADDR = '1;
    localparam logic [ADDR_WIDTH-1:0] BASE_PTR = ADDR_WIDTH'(LOAD_BASE);

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_LOAD,
        ST_RUN
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic                    ld_err_q, ld_err_d;
    logic                    ld_ready_q, ld_ready_d;
    logic                    run_q, run_d;

    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;

    logic [DATA_WIDTH-1:0]   mem_array [DEPTH];

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        ptr_d     = ptr_q;
        ld_err_d  = ld_err_q;
        wr_en     = 1'b0;
        wr_addr   = addr;
        wr_data   = data;

        unique case (state_q)
            ST_CLEAR: begin
                wr_en     = 1'b1;
                wr_addr   = clr_cnt_q;
                wr_data   = '0;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == TOP_ADDR) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (ld_ready_q && ld_valid) begin
                    wr_en   = 1'b1;
                    wr_addr = ptr_q;
                    wr_data = ld_data;
                    // The pointer saturates at the top address; overflow ends the load with an error.
                    if (ptr_q != TOP_ADDR) ptr_d = ptr_q + 1'b1;
                    if (ld_last) begin
                        state_d = ST_RUN;
                    end else if (ptr_q == TOP_ADDR) begin
                        ld_err_d = 1'b1;
                        state_d  = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                wr_en = we;
            end
            default: state_d = ST_CLEAR;
        endcase

        ld_ready_d = (state_d == ST_LOAD);
        run_d      = (state_d == ST_RUN);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_CLEAR;
            clr_cnt_q  <= '0;
            ptr_q      <= BASE_PTR;
            ld_err_q   <= 1'b0;
            ld_ready_q <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            ptr_q      <= ptr_d;
            ld_err_q   <= ld_err_d;
            ld_ready_q <= ld_ready_d;
            run_q      <= run_d;
        end
    end

    // NOTE: the array has no reset; the CLEAR sweep zeroes it, which keeps it mappable to RAM.
    always_ff @(posedge clk) begin
        if (wr_en) mem_array[wr_addr] <= wr_data;
    end

    assign mem      = run_q ? mem_array[addr] : '0;
    assign ld_ready = ld_ready_q;
    assign run      = run_q;
    assign ld_err   = ld_err_q;

endmodule

// File: tb/tb_memory_unit.sv
// Directed testbench for memory_unit: reset sweep, loader handshake, overflow, RUN access, resets.
module tb_memory_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  addr;
    logic [15:0] data;
    logic        we;
    logic [15:0] mem;
    logic        ld_valid;
    logic [15:0] ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic        run;
    logic        ld_err;

    int checks   = 0;
    int failures = 0;

    memory_unit #(.DATA_WIDTH(16), .ADDR_WIDTH(6), .LOAD_BASE(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .data     (data),
        .we       (we),
        .mem      (mem),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_last  (ld_last),
        .ld_ready (ld_ready),
        .run      (run),
        .ld_err   (ld_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_chk(input string tag, input logic [5:0] a, input logic [15:0] exp);
        addr = a;
        #1;
        check(tag, mem, exp);
    endtask

    // Count exactly 64 edges of CLEAR with ld_ready low, then expect LOAD.
    task automatic sweep();
        for (int i = 0; i < 64; i++) begin
            check("clear_ready_low", 16'(ld_ready), 16'h0);
            tick();
        end
        check("load_ready_high", 16'(ld_ready), 16'h1);
        check("load_run_low", 16'(run), 16'h0);
        check("load_mem_zero", mem, 16'h0000);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        check({tag, "_run"}, 16'(run), 16'h0);
        check({tag, "_ready"}, 16'(ld_ready), 16'h0);
        check({tag, "_err"}, 16'(ld_err), 16'h0);
        check({tag, "_mem"}, mem, 16'h0000);
        tick();
        rst = 1'b0;
        sweep();
    endtask

    task automatic load_word(input logic [15:0] d, input logic last);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; addr = '0; data = '0; we = 1'b0;
        ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
        #2;
        check("rst_run", 16'(run), 16'h0);
        check("rst_ready", 16'(ld_ready), 16'h0);
        check("rst_err", 16'(ld_err), 16'h0);
        check("rst_mem", mem, 16'h0000);
        tick();
        rst = 1'b0;
        sweep();

        // Short back-to-back load
        load_word(16'h1234, 1'b0);
        check("short_mid_run", 16'(run), 16'h0);
        load_word(16'hABCD, 1'b1);
        check("short_run", 16'(run), 16'h1);
        check("short_ready", 16'(ld_ready), 16'h0);
        check("short_err", 16'(ld_err), 16'h0);
        read_chk("short_a8", 6'd8, 16'h1234);
        read_chk("short_a9", 6'd9, 16'hABCD);
        read_chk("short_a10", 6'd10, 16'h0000);

        // Gapped handshake with a stray ld_last during the idle cycle
        do_reset("rst2");
        load_word(16'h1111, 1'b0);
        ld_data = 16'h2222; ld_last = 1'b1;
        tick();
        ld_last = 1'b0;
        check("gap_idle_run", 16'(run), 16'h0);
        check("gap_idle_ready", 16'(ld_ready), 16'h1);
        load_word(16'h3333, 1'b1);
        check("gap_run", 16'(run), 16'h1);
        read_chk("gap_a8", 6'd8, 16'h1111);
        read_chk("gap_a9", 6'd9, 16'h3333);
        read_chk("gap_a10", 6'd10, 16'h0000);

        // RUN write: same-cycle read returns old value, new value next cycle
        addr = 6'd5; data = 16'h00FF; we = 1'b1;
        #1;
        check("run_wr_old", mem, 16'h0000);
        tick();
        we = 1'b0;
        check("run_wr_new", mem, 16'h00FF);
        load_word(16'hDEAD, 1'b1);
        read_chk("run_ld_ignored_a8", 6'd8, 16'h1111);
        read_chk("run_ld_ignored_a10", 6'd10, 16'h0000);
        check("run_ready_low", 16'(ld_ready), 16'h0);

        // Overflow: 56 words without ld_last fill 8..63
        do_reset("rst3");
        for (int i = 0; i < 56; i++) begin
            if (i == 55) begin
                check("ovf_pre_run", 16'(run), 16'h0);
                check("ovf_pre_ready", 16'(ld_ready), 16'h1);
            end
            ld_valid = 1'b1;
            ld_data  = 16'h0100 + 16'(i);
            ld_last  = 1'b0;
            tick();
        end
        ld_valid = 1'b0;
        check("ovf_err", 16'(ld_err), 16'h1);
        check("ovf_run", 16'(run), 16'h1);
        check("ovf_ready", 16'(ld_ready), 16'h0);
        load_word(16'hBEEF, 1'b1);
        check("ovf_err_sticky", 16'(ld_err), 16'h1);
        read_chk("ovf_a63", 6'd63, 16'h0137);
        read_chk("ovf_a8", 6'd8, 16'h0100);
        read_chk("ovf_a0", 6'd0, 16'h0000);

        // Fill 0..7 with 0xFFFF so the next sweep has something to clear
        for (int a = 0; a < 8; a++) begin
            addr = 6'(a); data = 16'hFFFF; we = 1'b1;
            tick();
        end
        we = 1'b0;
        read_chk("fill_a0", 6'd0, 16'hFFFF);
        read_chk("fill_a7", 6'd7, 16'hFFFF);

        // Reset mid-run, then mid-load after three words
        addr = 6'd8;
        do_reset("rst_midrun");
        load_word(16'hA001, 1'b0);
        load_word(16'hA002, 1'b0);
        load_word(16'hA003, 1'b0);
        do_reset("rst_midload");
        load_word(16'h7777, 1'b1);
        check("final_run", 16'(run), 16'h1);
        check("final_err", 16'(ld_err), 16'h0);
        read_chk("final_a8", 6'd8, 16'h7777);
        read_chk("final_a9", 6'd9, 16'h0000);
        read_chk("final_a10", 6'd10, 16'h0000);
        read_chk("final_a11", 6'd11, 16'h0000);
        read_chk("final_a63", 6'd63, 16'h0000);
        for (int a = 0; a < 8; a++) begin
            read_chk("sweep_low", 6'(a), 16'h0000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
